fifo_flagged: RTL and testbench

Single-clock, parametrised FIFO that succeeds the basic push/pop FIFO. It uses all DEPTH entries, with extra-bit pointers distinguishing full from empty. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a read-data-valid strobe. It is used as the general-purpose buffer between datapath stages in the same clock domain.

---
 rtl/fifo_flagged_if.sv | 34 +++
 rtl/fifo_flagged.sv | 136 +++++++++++++
 tb/tb_fifo_flagged.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flagged_if.sv
// Handshake/status bundle between a producer/consumer and fifo_flagged.
// The slave modport is the FIFO side; the master modport is the user side.
interface fifo_flagged_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, din, pop, err_clr,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, din, pop, err_clr,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Define FIFO_FLAGGED_FWFT_EN for first-word fall-through reads; default is 1-cycle registered read.
module fifo_flagged #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_flagged_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_head;

  assign w_waddr = r_wptr[AW-1:0];
  assign w_raddr = r_rptr[AW-1:0];

  // Same slot index with differing wrap bits means every entry is occupied.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_waddr == w_raddr);
  assign w_empty = (r_wptr == r_rptr);

  // A pop on a full FIFO frees the head slot in the same cycle, so a push may follow it in.
  assign w_rd_ok = bus.pop & ~w_empty;
  assign w_wr_ok = bus.push & (~w_full | w_rd_ok);
  assign w_head  = r_mem[w_raddr];

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_waddr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + C_ONE;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + C_ONE;
      end
      r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    end
  end

  // A fresh error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.push & ~w_wr_ok) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (bus.pop & ~w_rd_ok) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FLAGGED_FWFT_EN
  // r_dout remembers the word last shown so dout can hold it once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (!w_empty) begin
      r_dout <= w_head;
    end
  end

  assign bus.dout       = w_empty ? r_dout : w_head;
  assign bus.dout_valid = ~w_empty;
`else
  logic r_dout_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_dout <= w_head;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Upper bound of the occupancy counter; kept for readability of the full condition.
  logic w_count_at_depth;
  assign w_count_at_depth = (r_count == C_DEPTH);

  logic w_unused;
  assign w_unused = w_count_at_depth;

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged: table vectors, directed corner sequences and
// a randomized stream checked against a queue-based reference model.
module tb_fifo_flagged;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_flagged_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

  fifo_flagged #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic [7:0] m_last;
  logic       m_dv;
  logic       m_ovf;
  logic       m_udf;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_last = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    check("count",        32'(bus.count),        32'(sz));
    check("full",         32'(bus.full),         32'(sz == DEPTH));
    check("empty",        32'(bus.empty),        32'(sz == 0));
    check("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_udf));
    check("dout_valid",   32'(bus.dout_valid),   32'(m_dv));
    check("dout",         32'(bus.dout),         32'(m_dout));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic step(input logic p, input logic [7:0] d, input logic po, input logic c);
    bit rd_ok;
    bit wr_ok;
    int sz;
    bus.push    = p;
    bus.din     = d;
    bus.pop     = po;
    bus.err_clr = c;
    sz = q.size();
    if (sz > 0) m_last = q[0];
    rd_ok = po && (sz > 0);
    wr_ok = p && ((sz < DEPTH) || rd_ok);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (p && !wr_ok) m_ovf = 1'b1;
    if (po && !rd_ok) m_udf = 1'b1;
`ifdef FIFO_FLAGGED_FWFT_EN
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(d);
    m_dv   = (q.size() > 0);
    m_dout = (q.size() > 0) ? q[0] : m_last;
`else
    m_dv = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
`endif
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    int reads;
    int cyc;
    int sz;
    logic p;
    logic po;

    rst = 1'b1;
    bus.push = 1'b0; bus.din = '0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_model();

    // Fill, overflow, drain, underflow and clear sequence.
    for (int i = 0; i < 8; i++)
      tv.push_back('{1'b1, 8'(8'h10 + i), 1'b0, 1'b0, i + 1, (i == 7), 1'b0,
                     (i + 1 >= AF), (i + 1 <= AE), 1'b0, 1'b0});
    tv.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++)
      tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 1'b0, (i == 7),
                     (7 - i >= AF), (7 - i <= AE), 1'b1, 1'b0});
    tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    foreach (tv[k]) begin
      step(tv[k].push, tv[k].din, tv[k].pop, tv[k].clr);
      check("tbl_count", 32'(bus.count),        32'(tv[k].cnt));
      check("tbl_full",  32'(bus.full),         32'(tv[k].full));
      check("tbl_empty", 32'(bus.empty),        32'(tv[k].empty));
      check("tbl_af",    32'(bus.almost_full),  32'(tv[k].af));
      check("tbl_ae",    32'(bus.almost_empty), 32'(tv[k].ae));
      check("tbl_ovf",   32'(bus.overflow),     32'(tv[k].ovf));
      check("tbl_udf",   32'(bus.underflow),    32'(tv[k].udf));
    end

    // Full FIFO with simultaneous push and pop: head 0x55 leaves, 0x77 enters last.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("pp_full_before", 32'(bus.full), 32'd1);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("pp_count", 32'(bus.count), 32'd8);
    check("pp_ovf",   32'(bus.overflow), 32'd0);
`ifdef FIFO_FLAGGED_FWFT_EN
    check("pp_dout", 32'(bus.dout), 32'h60);
`else
    check("pp_dout", 32'(bus.dout), 32'h55);
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_last_out", 32'(bus.dout), 32'h77);
    check("pp_empty",    32'(bus.empty), 32'd1);

    // Randomized stream over several pointer wraps.
    writes = 0; reads = 0; cyc = 0;
    while (writes < 40 && cyc < 2000) begin
      p  = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      sz = q.size();
      if (po && sz > 0) reads++;
      if (p && (sz < DEPTH || (po && sz > 0))) writes++;
      step(p, 8'($urandom), po, 1'($urandom_range(0, 7) == 0));
      check("wrap_count", 32'(bus.count), 32'(writes - reads));
      cyc++;
    end
    check("wrap_writes_done", 32'(writes >= 40), 32'd1);
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cyc++;
    end
    check("wrap_drained", 32'(bus.empty), 32'd1);

    // Asynchronous reset between clock edges with five words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("ar_count_before", 32'(bus.count), 32'd5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hC5, 1'b0, 1'b0);
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_count", 32'(bus.count),        32'd0);
    check("ar_empty", 32'(bus.empty),        32'd1);
    check("ar_ae",    32'(bus.almost_empty), 32'd1);
    check("ar_dv",    32'(bus.dout_valid),   32'd0);
    check("ar_full",  32'(bus.full),         32'd0);
    model_reset();
    #1 rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef FIFO_FLAGGED_FWFT_EN
    check("ar_fwft_dout", 32'(bus.dout),       32'h3C);
    check("ar_fwft_dv",   32'(bus.dout_valid), 32'd1);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FLAGGED_FWFT_EN
    check("ar_dout", 32'(bus.dout),       32'h3C);
    check("ar_dv2",  32'(bus.dout_valid), 32'd1);
`endif
    check("ar_empty_after", 32'(bus.empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
